// File: rtl/bounded_pulse_gen.sv
// bounded_pulse_gen: transmit driver for the bounded-duration pulse protocol.
// Accepts one pulse request at a time, clamps the requested width into
// [MIN_HIGH, MAX_HIGH], drives a registered pulse, and then holds at least
// MIN_LOW low cycles before the next request can be taken.
//
// Optional build macro BOUNDED_PULSE_GEN_ABORT_EN adds an abort input that
// truncates the current pulse but never below MIN_HIGH cycles.
//
// state | meaning
// IDLE  | ready for a request, pulse_out low
// HIGH  | driving pulse_out high, high counter running
// GAP   | enforced low run of MIN_LOW cycles after a pulse
module bounded_pulse_gen #(
  parameter int MIN_HIGH = 2,
  parameter int MAX_HIGH = 6,
  parameter int MIN_LOW  = 1,
  parameter int WIDTH_W  = 3,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH_W-1:0] width_in,
`ifdef BOUNDED_PULSE_GEN_ABORT_EN
  input  logic               abort,
`endif
  output logic               ready,
  output logic               pulse_out,
  output logic               done,
  output logic               clamped,
  output logic [CNT_W-1:0]   pulse_cnt
);

  // Elaboration-time parameter legality checks
  if (MIN_HIGH < 1) begin : g_bad_min_high
    $fatal(1, "bounded_pulse_gen: MIN_HIGH must be >= 1");
  end
  if (MAX_HIGH < MIN_HIGH) begin : g_bad_max_high
    $fatal(1, "bounded_pulse_gen: MAX_HIGH must be >= MIN_HIGH");
  end
  if (MAX_HIGH >= (1 << WIDTH_W)) begin : g_bad_width
    $fatal(1, "bounded_pulse_gen: MAX_HIGH must fit in WIDTH_W bits");
  end
  if (MIN_LOW < 1) begin : g_bad_min_low
    $fatal(1, "bounded_pulse_gen: MIN_LOW must be >= 1");
  end

  localparam int GAP_W = (MIN_LOW < 2) ? 1 : $clog2(MIN_LOW + 1);
  localparam logic [WIDTH_W-1:0] MIN_H  = WIDTH_W'(MIN_HIGH);
  localparam logic [WIDTH_W-1:0] MAX_H  = WIDTH_W'(MAX_HIGH);
  localparam logic [WIDTH_W-1:0] MIN_M1 = WIDTH_W'(MIN_HIGH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH_W-1:0] eff_w;
  logic               is_clamped;
  logic [WIDTH_W-1:0] high_left;   // high cycles remaining, including current
  logic [WIDTH_W-1:0] min_left;    // cycles until MIN_HIGH has been reached
  logic [GAP_W-1:0]   gap_left;    // gap cycles remaining, including current
  logic               clamp_flag;
  logic               abort_in;
  logic               abort_pend;
  logic               abort_act;
  logic               accept;
  logic               high_end;
  logic               gap_end;
  logic               pulse_d;
  logic               done_d;
  logic               clamped_d;

`ifdef BOUNDED_PULSE_GEN_ABORT_EN
  assign abort_in = abort;
`else
  assign abort_in = 1'b0;
`endif

  // Clamp the requested width into the legal range
  always_comb begin
    eff_w = width_in;
    if (width_in < MIN_H) begin
      eff_w = MIN_H;
    end else if (width_in > MAX_H) begin
      eff_w = MAX_H;
    end
    is_clamped = (eff_w != width_in);
  end

  // An abort seen before the minimum is reached is remembered until min_left expires
  assign abort_act = abort_in || abort_pend;
  assign accept    = (state == IDLE) && start;
  assign high_end  = (state == HIGH) &&
                     ((high_left == WIDTH_W'(1)) || (abort_act && (min_left == '0)));
  assign gap_end   = (state == GAP) && (gap_left == GAP_W'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = HIGH;
      HIGH:    if (high_end) state_nxt = GAP;
      GAP:     if (gap_end)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Down-counters and per-pulse latched attributes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_left  <= '0;
      min_left   <= '0;
      gap_left   <= '0;
      clamp_flag <= 1'b0;
      abort_pend <= 1'b0;
    end else if (accept) begin
      high_left  <= eff_w;
      min_left   <= MIN_M1;
      clamp_flag <= is_clamped;
      abort_pend <= 1'b0;
    end else if (state == HIGH) begin
      if (high_end) begin
        high_left  <= '0;
        min_left   <= '0;
        gap_left   <= GAP_W'(MIN_LOW);
        abort_pend <= 1'b0;
      end else begin
        high_left <= high_left - WIDTH_W'(1);
        if (min_left != '0) begin
          min_left <= min_left - WIDTH_W'(1);
        end
        if (abort_in) begin
          abort_pend <= 1'b1;
        end
      end
    end else if (state == GAP) begin
      gap_left <= gap_left - GAP_W'(1);
    end
  end

  // Output decode: ready straight from state, registered outputs from next state
  always_comb begin
    ready     = (state == IDLE);
    pulse_d   = (state_nxt == HIGH);
    done_d    = high_end;
    clamped_d = high_end && clamp_flag;
  end

  // Output registers and completed-pulse counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_out <= 1'b0;
      done      <= 1'b0;
      clamped   <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      pulse_out <= pulse_d;
      done      <= done_d;
      clamped   <= clamped_d;
      if (high_end) begin
        pulse_cnt <= pulse_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bounded_pulse_gen.sv
// Self-checking bench for bounded_pulse_gen. A schedule-queue model predicts
// every output cycle from the protocol rules; a run-length monitor checks
// the high/low duration bounds independently.
module tb_bounded_pulse_gen;

  localparam int MIN_HIGH = 2;
  localparam int MAX_HIGH = 6;
  localparam int MIN_LOW  = 1;
  localparam int WIDTH_W  = 3;
  localparam int CNT_W    = 16;
`ifdef BOUNDED_PULSE_GEN_ABORT_EN
  localparam bit ABORT_ON = 1'b1;
`else
  localparam bit ABORT_ON = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic               start;
  logic [WIDTH_W-1:0] width_in;
`ifdef BOUNDED_PULSE_GEN_ABORT_EN
  logic               abort;
`endif
  logic               ready;
  logic               pulse_out;
  logic               done;
  logic               clamped;
  logic [CNT_W-1:0]   pulse_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  bounded_pulse_gen #(
    .MIN_HIGH(MIN_HIGH), .MAX_HIGH(MAX_HIGH), .MIN_LOW(MIN_LOW),
    .WIDTH_W(WIDTH_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .width_in(width_in),
`ifdef BOUNDED_PULSE_GEN_ABORT_EN
    .abort(abort),
`endif
    .ready(ready),
    .pulse_out(pulse_out),
    .done(done),
    .clamped(clamped),
    .pulse_cnt(pulse_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: queue of scheduled output cycles following an accept
  typedef struct {
    bit p;
    bit d;
    bit c;
  } ent_t;
  ent_t q[$];
  bit   m_ready;
  bit   m_pulse;
  bit   m_done;
  bit   m_clamped;
  int   m_cnt;
  int   m_k;

  // Monitor state
  int  hi_run;
  int  lo_run;
  int  last_run;
  bit  seen_pulse;

  function automatic int clamp_w(input int w);
    if (w < MIN_HIGH) return MIN_HIGH;
    if (w > MAX_HIGH) return MAX_HIGH;
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ready    = 1'b1;
    m_pulse    = 1'b0;
    m_done     = 1'b0;
    m_clamped  = 1'b0;
    m_cnt      = 0;
    m_k        = 0;
    hi_run     = 0;
    lo_run     = 0;
    seen_pulse = 1'b0;
  endtask

  task automatic model_edge(input bit s, input int w, input bit a);
    ent_t e;
    int   eff;
    int   n;
    int   keep;
    if (m_ready && s) begin
      eff = clamp_w(w);
      for (int i = 0; i < eff; i++) q.push_back('{p: 1'b1, d: 1'b0, c: 1'b0});
      q.push_back('{p: 1'b0, d: 1'b1, c: (eff != w)});
      for (int i = 1; i < MIN_LOW; i++) q.push_back('{p: 1'b0, d: 1'b0, c: 1'b0});
    end else if (a && ABORT_ON && m_pulse) begin
      n = 0;
      while (n < q.size() && q[n].p) n++;
      keep = (m_k >= MIN_HIGH) ? 0 : MIN_HIGH - m_k;
      for (int i = 0; i < n - keep; i++) q.delete(0);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      m_ready   = 1'b0;
      m_pulse   = e.p;
      m_done    = e.d;
      m_clamped = e.c;
      if (e.d) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      m_k = e.p ? m_k + 1 : 0;
    end else begin
      m_ready   = 1'b1;
      m_pulse   = 1'b0;
      m_done    = 1'b0;
      m_clamped = 1'b0;
      m_k       = 0;
    end
  endtask

  // One clock: check at negedge, run monitor, drive inputs, advance model at posedge
  task automatic step(input bit s, input int w, input bit a);
    @(negedge clk);
    chk("ready", ready, m_ready);
    chk("pulse_out", pulse_out, m_pulse);
    chk("done", done, m_done);
    chk("clamped", clamped, m_clamped);
    chk("pulse_cnt", pulse_cnt, m_cnt);
    if (pulse_out) begin
      if (hi_run == 0 && seen_pulse) chk("low_run_min", (lo_run >= MIN_LOW), 1);
      hi_run++;
      lo_run = 0;
    end else begin
      if (hi_run > 0) begin
        last_run = hi_run;
        chk("high_run_range", (hi_run >= MIN_HIGH && hi_run <= MAX_HIGH), 1);
        seen_pulse = 1'b1;
      end
      hi_run = 0;
      lo_run++;
    end
    start    = s;
    width_in = WIDTH_W'(w);
`ifdef BOUNDED_PULSE_GEN_ABORT_EN
    abort    = a;
`endif
    @(posedge clk);
    model_edge(s, w, a);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
  endtask

  task automatic one_pulse(input int w, input int exp_len);
    step(1'b1, w, 1'b0);
    idle_steps(MAX_HIGH + MIN_LOW + 3);
    chk("pulse_len", last_run, exp_len);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    width_in = '0;
`ifdef BOUNDED_PULSE_GEN_ABORT_EN
    abort    = 1'b0;
`endif
    last_run = 0;
    model_reset();
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_pulse", pulse_out, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", pulse_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic width, clamps, boundary
    one_pulse(3, 3);
    one_pulse(1, 2);
    one_pulse(0, 2);
    one_pulse(7, 6);
    one_pulse(6, 6);
    one_pulse(2, 2);

    // Back-to-back with start held
    for (int i = 0; i < 24; i++) step(1'b1, 2, 1'b0);
    idle_steps(8);

    // Reset in the 3rd cycle of a 5-cycle pulse
    step(1'b1, 5, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    @(negedge clk);
    chk("mid_pulse_high", pulse_out, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_pulse", pulse_out, 0);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_cnt", pulse_cnt, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    model_reset();
    one_pulse(4, 4);

`ifdef BOUNDED_PULSE_GEN_ABORT_EN
    // Abort in 1st high cycle: held to MIN_HIGH
    step(1'b1, 6, 1'b0);
    step(1'b0, 0, 1'b1);
    idle_steps(MAX_HIGH + 3);
    chk("abort_early_len", last_run, MIN_HIGH);
    // Abort in 4th high cycle: ends on that edge
    step(1'b1, 6, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1);
    idle_steps(MAX_HIGH + 3);
    chk("abort_late_len", last_run, 4);
    // Abort with start in idle is ignored
    step(1'b1, 3, 1'b1);
    idle_steps(MAX_HIGH + 3);
    chk("abort_idle_len", last_run, 3);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 2) == 0), int'($urandom_range(0, (1 << WIDTH_W) - 1)),
           ABORT_ON && ($urandom_range(0, 5) == 0));
    end
    idle_steps(MAX_HIGH + MIN_LOW + 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
